// File: rtl/ghash_ctrl.sv
// GHASH sequencing controller: folds each input block into Y, hands Y^X to the
// bit-serial GF(2^128) multiplier, captures the product and emits T = Y_n ^ E(K,J0).
module ghash_ctrl (
    input  logic         iClk,
    input  logic         iRstn,
    input  logic         iStart,
    input  logic [127:0] iHashkey,
    input  logic [127:0] iEkj0,
    input  logic [127:0] iBlock,
    input  logic         iBlock_valid,
    input  logic         iBlock_last,
    output logic         oBlock_ready,
    output logic [127:0] oMul_ctext,
    output logic [127:0] oMul_hashkey,
    output logic         oMul_valid,
    input  logic [127:0] iMul_result,
    input  logic         iMul_result_valid,
    output logic [127:0] oTag,
    output logic         oTag_valid,
    output logic         oBusy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_MUL,
        S_DONE
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [127:0] r_hashkey;
    logic [127:0] r_mask;
    logic [127:0] r_y;
    logic [127:0] r_ctext;
    logic [127:0] r_tag;
    logic         r_last;

    // NOTE: reset is synchronous, so it is tested inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge iClk) begin
        if (!iRstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (iStart)            w_next = S_WAIT;
            S_WAIT:  if (iBlock_valid)      w_next = S_MUL;
            S_MUL:   if (iMul_result_valid) w_next = r_last ? S_DONE : S_WAIT;
            S_DONE:                         w_next = S_IDLE;
            default:                        w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClk) begin
        if (!iRstn) begin
            r_hashkey <= '0;
            r_mask    <= '0;
            r_y       <= '0;
            r_ctext   <= '0;
            r_tag     <= '0;
            r_last    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        r_hashkey <= iHashkey;
                        r_mask    <= iEkj0;
                        r_y       <= '0;
                    end
                end
                S_WAIT: begin
                    // Operand is registered so it stays frozen for the whole multiply.
                    if (iBlock_valid) begin
                        r_ctext <= r_y ^ iBlock;
                        r_last  <= iBlock_last;
                    end
                end
                S_MUL: begin
                    if (iMul_result_valid) begin
                        r_y <= iMul_result;
                        if (r_last) begin
                            r_tag <= iMul_result ^ r_mask;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are pure state decodes; valid drops the cycle after the result pulse.
    always_comb begin
        oBlock_ready = 1'b0;
        oMul_valid   = 1'b0;
        oTag_valid   = 1'b0;
        oBusy        = 1'b1;
        unique case (r_state)
            S_IDLE:  oBusy        = 1'b0;
            S_WAIT:  oBlock_ready = 1'b1;
            S_MUL:   oMul_valid   = 1'b1;
            S_DONE:  oTag_valid   = 1'b1;
            default: oBusy        = 1'b0;
        endcase
    end

    assign oMul_ctext   = r_ctext;
    assign oMul_hashkey = r_hashkey;
    assign oTag         = r_tag;

endmodule

// File: tb/tb_ghash_ctrl.sv
// Self-checking bench for ghash_ctrl: a behavioural 129-cycle GF(2^128) multiplier
// answers the controller, and a GHASH reference computes the expected tags.
module tb_ghash_ctrl;

    logic         iClk = 1'b0;
    logic         iRstn;
    logic         iStart;
    logic [127:0] iHashkey;
    logic [127:0] iEkj0;
    logic [127:0] iBlock;
    logic         iBlock_valid;
    logic         iBlock_last;
    logic         oBlock_ready;
    logic [127:0] oMul_ctext;
    logic [127:0] oMul_hashkey;
    logic         oMul_valid;
    logic [127:0] iMul_result;
    logic         iMul_result_valid;
    logic [127:0] oTag;
    logic         oTag_valid;
    logic         oBusy;

    localparam logic [127:0] NIST_H   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] NIST_M   = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [127:0] NIST_X1  = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] NIST_LEN = 128'h00000000000000000000000000000080;
    localparam logic [127:0] NIST_T   = 128'hab6e47d42cec13bdf53a67b21257bddf;
    localparam logic [127:0] MASK2    = 128'h0123456789abcdeffedcba9876543210;

    localparam int M_NORMAL  = 0;
    localparam int M_DISTURB = 1;
    localparam int M_HOLD    = 2;
    localparam int M_RESET   = 3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] h_exp;
    logic [127:0] m_exp;
    logic [127:0] y_exp;
    logic [127:0] blk_q [$];

    ghash_ctrl dut (
        .iClk             (iClk),
        .iRstn            (iRstn),
        .iStart           (iStart),
        .iHashkey         (iHashkey),
        .iEkj0            (iEkj0),
        .iBlock           (iBlock),
        .iBlock_valid     (iBlock_valid),
        .iBlock_last      (iBlock_last),
        .oBlock_ready     (oBlock_ready),
        .oMul_ctext       (oMul_ctext),
        .oMul_hashkey     (oMul_hashkey),
        .oMul_valid       (oMul_valid),
        .iMul_result      (iMul_result),
        .iMul_result_valid(iMul_result_valid),
        .oTag             (oTag),
        .oTag_valid       (oTag_valid),
        .oBusy            (oBusy)
    );

    always #5 iClk = ~iClk;

    // GCM multiply in the reflected bit order: bit 127 of the vector is x^0.
    function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z;
        logic [127:0] v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
        end
        return z;
    endfunction

    function automatic logic [127:0] ghash_ref(input logic [127:0] h, input logic [127:0] m);
        logic [127:0] y;
        y = '0;
        foreach (blk_q[i]) y = gf_mul(y ^ blk_q[i], h);
        return y ^ m;
    endfunction

    // Multiplier model: result pulse in the 129th cycle of valid, counter wraps to 0 on it.
    int           mcnt;
    logic [127:0] mprod;
    always @(posedge iClk) begin
        if (!iRstn) begin
            mcnt <= 0;
        end else if (oMul_valid) begin
            if (mcnt == 0) mprod <= gf_mul(oMul_ctext, oMul_hashkey);
            mcnt <= (mcnt == 128) ? 0 : mcnt + 1;
        end
    end
    assign iMul_result_valid = oMul_valid && (mcnt == 128);
    assign iMul_result       = mprod;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, oBlock_ready, 0);
        check({tag, "_mulv"},  oMul_valid, 0);
        check({tag, "_ctext"}, oMul_ctext, 0);
        check({tag, "_hkey"},  oMul_hashkey, 0);
        check({tag, "_tag"},   oTag, 0);
        check({tag, "_tagv"},  oTag_valid, 0);
        check({tag, "_busy"},  oBusy, 0);
    endtask

    task automatic do_start(input logic [127:0] h, input logic [127:0] m);
        iHashkey = h;
        iEkj0    = m;
        iStart   = 1'b1;
        tick();
        iStart   = 1'b0;
        iHashkey = rnd128();
        iEkj0    = rnd128();
        h_exp    = h;
        m_exp    = m;
        y_exp    = '0;
        blk_q.delete();
        check("start_ready", oBlock_ready, 1);
        check("start_busy", oBusy, 1);
    endtask

    task automatic send_block(input logic [127:0] x, input logic last, input int stall, input int mode);
        logic [127:0] op;
        int           waited;
        int           bad_mul;
        waited = 0;
        while (!oBlock_ready && waited < 300) begin
            tick();
            waited++;
        end
        check("ready_wait", oBlock_ready, 1);
        if (!oBlock_ready) return;
        for (int s = 0; s < stall; s++) begin
            check("stall_mulv", oMul_valid, 0);
            check("stall_ready", oBlock_ready, 1);
            tick();
        end
        iBlock       = x;
        iBlock_last  = last;
        iBlock_valid = 1'b1;
        op           = y_exp ^ x;
        blk_q.push_back(x);
        tick();
        if (mode != M_HOLD) begin
            iBlock_valid = 1'b0;
            iBlock       = rnd128();
            iBlock_last  = 1'($urandom_range(0, 1));
        end
        bad_mul = 0;
        for (int k = 1; k <= 129; k++) begin
            if (oMul_valid !== 1'b1 || oBlock_ready !== 1'b0 || oBusy !== 1'b1 ||
                oMul_ctext !== op || oMul_hashkey !== h_exp || oTag_valid !== 1'b0) bad_mul++;
            if (mode == M_RESET && k == 60) begin
                check("mul_window_pre_reset", bad_mul, 0);
                iRstn = 1'b0;
                tick();
                iRstn = 1'b1;
                check_reset_outputs("midmul_rst");
                return;
            end
            if (mode == M_DISTURB && k == 30) begin
                iStart       = 1'b1;
                iHashkey     = rnd128();
                iEkj0        = rnd128();
                iBlock_valid = 1'b1;
                iBlock       = rnd128();
                iBlock_last  = 1'b1;
            end
            if (mode == M_DISTURB && k == 31) begin
                iStart       = 1'b0;
                iBlock_valid = 1'b0;
            end
            if (mode == M_HOLD && k == 129) iBlock_valid = 1'b0;
            if (k < 129) tick();
        end
        check("mul_window", bad_mul, 0);
        tick();
        y_exp = gf_mul(op, h_exp);
        if (last) begin
            check("tag_valid_pulse", oTag_valid, 1);
            check("tag_value", oTag, y_exp ^ m_exp);
            check("tag_ready_low", oBlock_ready, 0);
            tick();
            check("tag_valid_drop", oTag_valid, 0);
            check("idle_busy_low", oBusy, 0);
        end else begin
            check("ready_again", oBlock_ready, 1);
            check("no_tag_mid", oTag_valid, 0);
        end
    endtask

    initial begin
        int           nblk;
        logic [127:0] h;
        logic [127:0] m;
        iRstn        = 1'b0;
        iStart       = 1'b0;
        iHashkey     = '0;
        iEkj0        = '0;
        iBlock       = '0;
        iBlock_valid = 1'b0;
        iBlock_last  = 1'b0;
        h_exp        = '0;
        m_exp        = '0;
        y_exp        = '0;
        repeat (3) tick();
        iRstn = 1'b1;
        check_reset_outputs("reset");

        // Blocks offered in IDLE are ignored.
        iBlock       = rnd128();
        iBlock_valid = 1'b1;
        repeat (3) tick();
        check("idle_ignore_ready", oBlock_ready, 0);
        check("idle_ignore_mulv", oMul_valid, 0);
        check("idle_ignore_busy", oBusy, 0);
        iBlock_valid = 1'b0;

        // NIST GCM case 2.
        do_start(NIST_H, NIST_M);
        send_block(NIST_X1, 1'b0, 0, M_NORMAL);
        send_block(NIST_LEN, 1'b1, 0, M_NORMAL);
        check("nist_tag", oTag, NIST_T);

        // H = 0 collapses the tag to the mask; start again right at t+131.
        do_start('0, MASK2);
        for (int i = 0; i < 3; i++) send_block(rnd128(), i == 2, 0, M_NORMAL);
        check("h0_tag", oTag, MASK2);

        // Start/block pulses during MUL, then a block held valid across MUL.
        do_start(NIST_H, NIST_M);
        send_block(NIST_X1, 1'b0, 0, M_DISTURB);
        send_block(NIST_LEN, 1'b1, 0, M_HOLD);
        check("disturb_tag", oTag, NIST_T);
        check("hold_not_reconsumed", oBusy, 0);

        // Reset in the middle of a multiply, then a clean rerun.
        do_start(NIST_H, NIST_M);
        send_block(NIST_X1, 1'b0, 0, M_RESET);
        tick();
        check("post_reset_busy", oBusy, 0);
        do_start(NIST_H, NIST_M);
        send_block(NIST_X1, 1'b0, 0, M_NORMAL);
        send_block(NIST_LEN, 1'b1, 0, M_NORMAL);
        check("post_reset_tag", oTag, NIST_T);

        // Source stall of 50 cycles between blocks.
        do_start(NIST_H, NIST_M);
        send_block(NIST_X1, 1'b0, 0, M_NORMAL);
        send_block(NIST_LEN, 1'b1, 50, M_NORMAL);
        check("stall_tag", oTag, NIST_T);

        // Randomised runs against the GHASH reference, including single-block.
        for (int r = 0; r < 5; r++) begin
            h    = rnd128();
            m    = rnd128();
            nblk = (r == 0) ? 1 : int'($urandom_range(1, 4));
            repeat ($urandom_range(0, 4)) tick();
            do_start(h, m);
            for (int i = 0; i < nblk; i++)
                send_block(rnd128(), i == nblk - 1, int'($urandom_range(0, 5)), M_NORMAL);
            check("rand_tag", oTag, ghash_ref(h, m));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
